// File: rtl/babbage_pkg.sv
// babbage_pkg: shared widths, config selector encodings and sweep state for the Babbage sequencer
package babbage_pkg;
    localparam int AW     = 2;
    localparam int BW     = 3;
    localparam int CW     = 4;
    localparam int DW     = 4;
    localparam int FW     = 6;
    localparam int GW     = 10;
    localparam int RW     = 32;
    localparam int NW_DEF = 7;

    typedef enum logic [2:0] {
        SEL_A, SEL_B, SEL_C, SEL_D, SEL_F, SEL_G, SEL_NFIRST, SEL_NLAST
    } cfg_sel_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_EMIT, S_FINISH
    } state_e;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [FW-1:0] f;
        logic [GW-1:0] g;
    } coef_t;
endpackage

// File: rtl/babbage_coef_regs.sv
// babbage_coef_regs: cfg-writable shadow coefficients/range plus the per-sweep coefficient snapshot
module babbage_coef_regs
    import babbage_pkg::*;
#(
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [2:0]    sel,
    input  logic [9:0]    data,
    input  logic          snap,
    output logic [NW-1:0] n_first,
    output logic [NW-1:0] n_last,
    output logic [AW-1:0] a,
    output logic [BW-1:0] b,
    output logic [CW-1:0] c,
    output logic [DW-1:0] d,
    output logic [FW-1:0] f,
    output logic [GW-1:0] g
);
    coef_t         shadow_q, snap_q;
    logic [NW-1:0] n_first_q, n_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '0;
            snap_q    <= '0;
            n_first_q <= '0;
            n_last_q  <= '0;
        end else begin
            if (we)
                case (cfg_sel_e'(sel))
                    SEL_A:      shadow_q.a <= data[AW-1:0];
                    SEL_B:      shadow_q.b <= data[BW-1:0];
                    SEL_C:      shadow_q.c <= data[CW-1:0];
                    SEL_D:      shadow_q.d <= data[DW-1:0];
                    SEL_F:      shadow_q.f <= data[FW-1:0];
                    SEL_G:      shadow_q.g <= data[GW-1:0];
                    SEL_NFIRST: n_first_q  <= data[NW-1:0];
                    SEL_NLAST:  n_last_q   <= data[NW-1:0];
                endcase
            if (snap)
                snap_q <= shadow_q;
        end
    end

    assign n_first = n_first_q;
    assign n_last  = n_last_q;
    assign a       = snap_q.a;
    assign b       = snap_q.b;
    assign c       = snap_q.c;
    assign d       = snap_q.d;
    assign f       = snap_q.f;
    assign g       = snap_q.g;
endmodule

// File: rtl/babbage_sweep_ctrl.sv
// babbage_sweep_ctrl: sweeps n over [n_first, n_last] through the difference engine and streams (n, result)
module babbage_sweep_ctrl
    import babbage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int NW          = NW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_sel,
    input  logic [9:0]    cfg_data,
    input  logic          sweep_start,
    input  logic          abort,
    input  logic          engine_ready,
    input  logic          engine_done,
    input  logic [RW-1:0] engine_result,
    output logic          engine_start,
    output logic [AW-1:0] engine_a,
    output logic [BW-1:0] engine_b,
    output logic [CW-1:0] engine_c,
    output logic [DW-1:0] engine_d,
    output logic [FW-1:0] engine_f,
    output logic [GW-1:0] engine_g,
    output logic [NW-1:0] engine_n,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] out_n,
    output logic [RW-1:0] out_value,
    output logic          busy,
    output logic          sweep_done,
    output logic          err_range,
    output logic          err_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    state_e        state_q, state_d;
    logic [NW-1:0] n_first, n_last, n_q, out_n_q;
    logic [RW-1:0] out_value_q;
    logic [TW-1:0] tmo_q;
    logic          err_range_q, err_timeout_q, range_pulse_q;
    logic          idle, range_bad, start_ok, last, tmo_hit, kill, emit_hs;

    assign idle      = state_q == S_IDLE;
    assign range_bad = n_first > n_last;
    assign start_ok  = idle && sweep_start && !range_bad;
    assign last      = n_q == n_last;
    // tmo_q counts WAIT cycles from 0, so expiry lands TIMEOUT_CYC cycles after the start pulse
    assign tmo_hit   = tmo_q == TW'(TIMEOUT_CYC - 2);
    assign kill      = abort && !idle;
    assign emit_hs   = state_q == S_EMIT && out_ready;

    babbage_coef_regs #(.NW(NW)) u_coef (
        .clk     (clk),
        .reset   (reset),
        .we      (cfg_we && idle),
        .sel     (cfg_sel),
        .data    (cfg_data),
        .snap    (start_ok),
        .n_first (n_first),
        .n_last  (n_last),
        .a       (engine_a),
        .b       (engine_b),
        .c       (engine_c),
        .d       (engine_d),
        .f       (engine_f),
        .g       (engine_g)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = start_ok ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_d = engine_ready ? S_WAIT : S_LAUNCH;
            S_WAIT:   state_d = engine_done ? S_EMIT : (tmo_hit ? S_FINISH : S_WAIT);
            S_EMIT:   state_d = out_ready ? (last ? S_FINISH : S_LAUNCH) : S_EMIT;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (kill)
            state_d = S_IDLE;
    end

    always_comb begin
        engine_start = state_q == S_LAUNCH && engine_ready && !abort;
        out_valid    = state_q == S_EMIT;
        busy         = !idle;
        sweep_done   = (state_q == S_FINISH && !abort) || range_pulse_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q           <= '0;
            tmo_q         <= '0;
            out_n_q       <= '0;
            out_value_q   <= '0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            range_pulse_q <= 1'b0;
        end else begin
            if (start_ok)
                n_q <= n_first;
            else if (emit_hs && !last && !kill)
                n_q <= n_q + 1'b1;
            tmo_q <= state_q == S_WAIT ? tmo_q + 1'b1 : '0;
            if (state_q == S_WAIT && engine_done && !kill) begin
                out_n_q     <= n_q;
                out_value_q <= engine_result;
            end
            if (idle && sweep_start)
                err_range_q <= range_bad;
            if (start_ok)
                err_timeout_q <= 1'b0;
            else if (state_q == S_WAIT && !engine_done && tmo_hit && !kill)
                err_timeout_q <= 1'b1;
            range_pulse_q <= idle && sweep_start && range_bad;
        end
    end

    assign engine_n    = n_q;
    assign out_n       = out_n_q;
    assign out_value   = out_value_q;
    assign err_range   = err_range_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_babbage_sweep_ctrl.sv
// tb_babbage_sweep_ctrl: directed sweeps against a behavioural engine with a queue-based result scoreboard
module tb_babbage_sweep_ctrl;
    localparam int NW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_sel = '0;
    logic [9:0]    cfg_data = '0;
    logic          sweep_start = 1'b0;
    logic          abort = 1'b0;
    logic          engine_ready, engine_done, engine_start;
    logic [31:0]   engine_result;
    logic [1:0]    engine_a;
    logic [2:0]    engine_b;
    logic [3:0]    engine_c, engine_d;
    logic [5:0]    engine_f;
    logic [9:0]    engine_g;
    logic [NW-1:0] engine_n, out_n;
    logic          out_valid, busy, sweep_done, err_range, err_timeout;
    logic          out_ready = 1'b1;
    logic [31:0]   out_value;

    babbage_sweep_ctrl #(.TIMEOUT_CYC(16), .NW(NW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .sweep_start(sweep_start), .abort(abort), .engine_ready(engine_ready),
        .engine_done(engine_done), .engine_result(engine_result), .engine_start(engine_start),
        .engine_a(engine_a), .engine_b(engine_b), .engine_c(engine_c), .engine_d(engine_d),
        .engine_f(engine_f), .engine_g(engine_g), .engine_n(engine_n), .out_valid(out_valid),
        .out_ready(out_ready), .out_n(out_n), .out_value(out_value), .busy(busy),
        .sweep_done(sweep_done), .err_range(err_range), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int exp_n[$], exp_v[$];
    int lat = 5, eng_cnt = 0, start_cnt = 0, done_cnt = 0, cyc = 0;
    bit never_done = 1'b0;
    logic eng_busy = 1'b0, eng_done = 1'b0;
    logic [31:0] eng_res = '0;

    assign engine_ready  = !eng_busy;
    assign engine_done   = eng_done;
    assign engine_result = eng_res;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] poly(logic [NW-1:0] n);
        longint x = longint'(n);
        longint r = $signed(engine_a);
        r = r * x + $signed(engine_b);
        r = r * x + $signed(engine_c);
        r = r * x + $signed(engine_d);
        r = r * x + $signed(engine_f);
        r = r * x + $signed(engine_g);
        return r[31:0];
    endfunction

    // behavioural engine: result valid lat cycles after start, optionally never reports done
    always @(posedge clk) begin
        cyc <= cyc + 1;
        eng_done <= 1'b0;
        if (engine_start) begin
            start_cnt <= start_cnt + 1;
            eng_busy  <= 1'b1;
            eng_cnt   <= lat;
            eng_res   <= poly(engine_n);
        end else if (eng_busy) begin
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_done <= !never_done;
            end
            eng_cnt <= eng_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (sweep_done)
            done_cnt++;
        if (out_valid && out_ready) begin
            if (exp_n.size() == 0)
                chk("out_unexpected", out_valid, 0);
            else begin
                chk("out_n", out_n, exp_n.pop_front());
                chk("out_value", out_value, exp_v.pop_front());
            end
        end
    end

    task automatic step(int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic cfg(logic [2:0] s, logic [9:0] d);
        cfg_we = 1'b1; cfg_sel = s; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
    endtask

    task automatic push(int n, int v);
        exp_n.push_back(n);
        exp_v.push_back(v);
    endtask

    task automatic push_all();
        push(0, 5); push(1, 6); push(2, 37); push(3, 248);
    endtask

    task automatic wait_done(int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = sweep_done;
        end
        chk("sweep_done_seen", hit, 1);
        step();
    endtask

    task automatic wait_valid(int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = out_valid;
        end
        chk("out_valid_seen", hit, 1);
    endtask

    initial begin
        int s0, d0, t0, tt, v;
        bit b, sd;
        step(3);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_range", err_range, 0);
        chk("rst_err_timeout", err_timeout, 0);
        step();
        reset = 1'b0;
        step();

        // 1: plain sweep 0..3 of n^5 + 5
        cfg(0, 1); cfg(1, 0); cfg(2, 0); cfg(3, 0); cfg(4, 0); cfg(5, 5); cfg(6, 0); cfg(7, 3);
        push_all();
        s0 = start_cnt; d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_engine_a", engine_a, 1);
        chk("t1_engine_g", engine_g, 5);
        wait_done(200);
        chk("t1_starts", start_cnt - s0, 4);
        chk("t1_done_pulses", done_cnt - d0, 1);
        @(negedge clk);
        chk("t1_idle", busy, 0);
        chk("t1_sb_empty", exp_n.size(), 0);
        step();

        // 2: inverted range
        cfg(6, 10); cfg(7, 9);
        s0 = start_cnt; d0 = done_cnt;
        pulse_start();
        b = 1'b0;
        repeat (4) begin
            @(negedge clk);
            b |= busy;
        end
        step();
        chk("t2_busy_seen", b, 0);
        chk("t2_err_range", err_range, 1);
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_starts", start_cnt - s0, 0);

        // 3: backpressure at n=1
        cfg(6, 0); cfg(7, 3);
        push_all();
        out_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("t3_err_range_cleared", err_range, 0);
        wait_valid(50);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_valid(50);
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_n", out_n, 1);
            chk("t3_hold_value", out_value, 6);
        end
        step();
        chk("t3_no_start_while_stalled", start_cnt - s0, 0);
        out_ready = 1'b1;
        wait_done(200);
        chk("t3_sb_empty", exp_n.size(), 0);

        // 4: engine never finishes
        never_done = 1'b1;
        pulse_start();
        t0 = -1;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            if (engine_start) t0 = cyc;
        end
        tt = -1; sd = 1'b0;
        for (int i = 0; i < 100 && tt < 0; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                tt = cyc;
                sd = sweep_done;
            end
        end
        chk("t4_timeout_latency", tt - t0, 16);
        chk("t4_done_at_timeout", sd, 1);
        @(negedge clk);
        chk("t4_idle", busy, 0);
        step(8);
        chk("t4_sb_empty", exp_n.size(), 0);
        never_done = 1'b0;

        // 5: abort while waiting on n=2, late done must vanish
        lat = 10;
        push(0, 5); push(1, 6);
        d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        chk("t5_err_timeout_cleared", err_timeout, 0);
        b = 1'b0;
        for (int i = 0; i < 100 && !b; i++) begin
            @(negedge clk);
            b = engine_start && engine_n == 2;
        end
        chk("t5_start_n2_seen", b, 1);
        step(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_abort", busy, 0);
        v = 0;
        repeat (20) begin
            @(negedge clk);
            v += int'(out_valid);
        end
        step();
        chk("t5_valid_after_abort", v, 0);
        chk("t5_no_done_pulse", done_cnt - d0, 0);
        chk("t5_sb_empty", exp_n.size(), 0);
        lat = 5;
        push_all();
        pulse_start();
        @(negedge clk);
        chk("t5_restart_n", engine_n, 0);
        wait_done(300);
        chk("t5_restart_sb_empty", exp_n.size(), 0);

        // 6: cfg write ignored while busy, reset in EMIT
        out_ready = 1'b0;
        pulse_start();
        step(2);
        cfg(5, 10'h3FD);
        wait_valid(50);
        chk("t6_engine_g", engine_g, 5);
        chk("t6_out_value", out_value, 5);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_out_n", out_n, 0);
        chk("t6_rst_out_value", out_value, 0);
        chk("t6_rst_engine_g", engine_g, 0);
        chk("t6_rst_engine_a", engine_a, 0);
        chk("t6_rst_engine_start", engine_start, 0);
        chk("t6_rst_sweep_done", sweep_done, 0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step(12);
        chk("t6_idle_after_reset", busy, 0);
        chk("final_sb_empty", exp_n.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
